zet_int_sched: RTL and testbench
================================

// Module: zet_int_sched
// PURPOSE
//  Interrupt scheduler in front of the Zet decoder's interrupt inputs.
//  - Latches 8 edge-triggered IRQ lines plus one NMI pin.
//  - Prioritises pending IRQs against a mask and an in-service set, and drives intr/nmir to the decoder.
//  - On the decoder's inta/nmia pulse, commits the winner to in-service and presents its vector for the interrupt microcode.
// PARAMETERS
//  VEC_BASE  8'h08  vector number for IRQ0; IRQn -> VEC_BASE+n (8-bit wrap)
//  SPUR_IRQ  3'd7   index whose vector is returned on a spurious acknowledge
// PORTS
//  clk        in   1  clock; all state changes on posedge
//  rst        in   1  synchronous, active-high reset
//  irq        in   8  IRQ lines, rising-edge sensitive, synchronous to clk
//  nmi_in     in   1  NMI pin, rising-edge sensitive
//  imr_we     in   1  write strobe for mask register
//  imr_wdata  in   8  new mask value (1 = masked)
//  eoi        in   1  end-of-interrupt pulse (non-specific)
//  inta       in   1  decoder acknowledge pulse for maskable interrupt
//  nmia       in   1  decoder acknowledge pulse for NMI
//  intr       out  1  maskable request to decoder
//  nmir       out  1  NMI request to decoder
//  vec        out  8  vector number of last acknowledge
//  vec_valid  out  1  one-cycle strobe: vec updated this cycle
//  imr        out  8  current mask register
//  irr        out  8  request register
//  isr        out  8  in-service register
// BEHAVIOUR
//  Reset: intr=0, nmir=0, vec=0, vec_valid=0, irr=0, isr=0, imr=8'hFF, edge history=0.
//   An irq/nmi_in already high when rst drops counts as a rising edge.
//  Edge detect: irq_d <= irq. Set irr[n] the cycle after irq[n] & ~irq_d[n]. NMI detects edges the same way.
//  IMR: imr <= imr_wdata on the cycle after imr_we. Masking only gates requests; irr bits are kept.
//  Arbitration (comb., fixed priority, bit 0 highest):
//   - pend = irr & ~imr; p = lowest set index in pend.
//   - elig = |pend && no isr bit at index <= p.
//  FSM states IDLE, REQ, ACK (intr = 1 only in REQ):
//   - IDLE -> REQ when elig.
//   - REQ -> IDLE when !elig and !inta (intr drops next cycle).
//   - inta in any state -> ACK.
//   - ACK -> IDLE unconditionally. ACK lasts 1 cycle.
//  Acknowledge (cycle inta=1, p/elig sampled that cycle; updates visible in ACK):
//   - elig: isr[p]<=1, irr[p]<=0, vec<=VEC_BASE+p, vec_valid=1.
//   - !elig (spurious): vec<=VEC_BASE+SPUR_IRQ, vec_valid=1, isr and irr unchanged.
//  vec holds its value until the next acknowledge; vec_valid is high only in ACK.
//  EOI: clears the lowest set isr bit; no-op if isr=0.
//  Simultaneous events:
//   - eoi + inta: apply the EOI clear to the old isr, then set the new bit.
//   - irq edge + ack clear of the same irr bit: set wins, irr[n] stays 1.
//   - imr_we + inta: arbitration uses the old imr.
//  NMI:
//   - nmir is set the cycle after a nmi_in rising edge and cleared the cycle after nmia.
//   - New edge + nmia in the same cycle: nmir stays 1.
//   - NMI is independent of imr/isr and does not touch vec.
//  Reset mid-operation: every register returns to its reset value on the next edge, regardless of state.
// TESTING
//  - Reset, imr_we 8'h00, rise irq[3] -> irr=8'h08 +1 cycle; intr=1 +2 cycles; inta pulse -> isr=8'h08, irr=0, vec=8'h0B, vec_valid 1 cycle.
//  - irq[5] then irq[2] both pending, no inta -> first inta vec=8'h0A; irq[5] blocked until eoi; after eoi next inta vec=8'h0D.
//  - isr=8'h04, rise irq[1] -> intr=1 (preemption); inta -> isr=8'h06; one eoi -> isr=8'h04.
//  - intr=1 for irq[4], write imr=8'h10 -> intr drops; inta arrives anyway -> vec=8'h0F, isr unchanged, irr[4] still 1.
//  - nmi_in edge with imr=8'hFF -> nmir=1, intr=0; nmia pulse -> nmir=0; edge coinciding with nmia -> nmir stays 1.
//  - Assert rst while in ACK with isr=8'h01 -> next cycle all outputs at reset values, imr=8'hFF.

Source files
------------

// File: rtl/zet_int_sched.sv
// Interrupt scheduler for the Zet decoder: latches edge-triggered IRQs and NMI,
// arbitrates against mask and in-service state, and supplies the acknowledge vector.
module zet_int_sched #(
  parameter logic [7:0] VEC_BASE = 8'h08,
  parameter logic [2:0] SPUR_IRQ = 3'd7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irq,
  input  logic       nmi_in,
  input  logic       imr_we,
  input  logic [7:0] imr_wdata,
  input  logic       eoi,
  input  logic       inta,
  input  logic       nmia,
  output logic       intr,
  output logic       nmir,
  output logic [7:0] vec,
  output logic       vec_valid,
  output logic [7:0] imr,
  output logic [7:0] irr,
  output logic [7:0] isr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } state_t;

  function automatic logic [2:0] lowest_idx(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  function automatic logic [7:0] le_mask(input logic [2:0] p);
    logic [7:0] m;
    m = 8'h00;
    for (int i = 0; i < 8; i++) begin
      m[i] = (3'(i) <= p);
    end
    return m;
  endfunction

  state_t     state_r, state_next_s;
  logic [7:0] irq_d_r, irr_r, isr_r, imr_r, vec_r;
  logic       nmi_d_r, nmir_r, vec_valid_r, intr_r;
  logic [7:0] irq_rise_s, pend_s, isr_eoi_s, irr_next_s, isr_next_s, ack_bit_s;
  logic [2:0] p_s;
  logic       elig_s, ack_s, nmi_rise_s;

  assign irq_rise_s = irq & ~irq_d_r;
  assign nmi_rise_s = nmi_in & ~nmi_d_r;
  assign pend_s     = irr_r & ~imr_r;
  assign p_s        = lowest_idx(pend_s);
  assign elig_s     = (pend_s != 8'h00) && ((isr_r & le_mask(p_s)) == 8'h00);
  assign ack_s      = inta & elig_s;
  assign ack_bit_s  = ack_s ? (8'h01 << p_s) : 8'h00;

  // Next-state request/acknowledge sequencing; an acknowledge overrides every state.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    if (elig_s) state_next_s = REQ; else state_next_s = IDLE;
      REQ:     if (!elig_s) state_next_s = IDLE; else state_next_s = REQ;
      ACK:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
    if (inta) state_next_s = ACK;
    else state_next_s = state_next_s;
  end

  // EOI clears the lowest in-service bit before a same-cycle acknowledge sets a new one.
  always_comb begin
    isr_eoi_s = isr_r;
    if (eoi) isr_eoi_s = isr_r & (isr_r - 8'd1);
    else isr_eoi_s = isr_r;
    isr_next_s = isr_eoi_s | ack_bit_s;
    irr_next_s = (irr_r & ~ack_bit_s) | irq_rise_s;
  end

  // Architectural state, edge history and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      irq_d_r     <= 8'h00;
      nmi_d_r     <= 1'b0;
      irr_r       <= 8'h00;
      isr_r       <= 8'h00;
      imr_r       <= 8'hFF;
      vec_r       <= 8'h00;
      vec_valid_r <= 1'b0;
      nmir_r      <= 1'b0;
      intr_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      irq_d_r     <= irq;
      nmi_d_r     <= nmi_in;
      irr_r       <= irr_next_s;
      isr_r       <= isr_next_s;
      imr_r       <= imr_we ? imr_wdata : imr_r;
      vec_valid_r <= inta;
      intr_r      <= (state_next_s == REQ);
      if (inta) begin
        vec_r <= elig_s ? (VEC_BASE + {5'd0, p_s}) : (VEC_BASE + {5'd0, SPUR_IRQ});
      end else begin
        vec_r <= vec_r;
      end
      // A new NMI edge wins over a same-cycle acknowledge.
      if (nmi_rise_s) nmir_r <= 1'b1;
      else if (nmia) nmir_r <= 1'b0;
      else nmir_r <= nmir_r;
    end
  end

  assign intr      = intr_r;
  assign nmir      = nmir_r;
  assign vec       = vec_r;
  assign vec_valid = vec_valid_r;
  assign imr       = imr_r;
  assign irr       = irr_r;
  assign isr       = isr_r;

endmodule

// File: tb/tb_zet_int_sched.sv
// Self-checking bench for zet_int_sched: scenario tasks with a vector scoreboard queue.
module tb_zet_int_sched;

  logic       clk = 1'b0;
  logic       rst, nmi_in, imr_we, eoi, inta, nmia;
  logic [7:0] irq, imr_wdata;
  logic       intr, nmir, vec_valid;
  logic [7:0] vec, imr, irr, isr;

  int         total_cnt = 0;
  int         pass_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;

  zet_int_sched dut (
    .clk(clk), .rst(rst), .irq(irq), .nmi_in(nmi_in), .imr_we(imr_we),
    .imr_wdata(imr_wdata), .eoi(eoi), .inta(inta), .nmia(nmia),
    .intr(intr), .nmir(nmir), .vec(vec), .vec_valid(vec_valid),
    .imr(imr), .irr(irr), .isr(isr)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_imr(input logic [7:0] v);
    imr_wdata = v; imr_we = 1'b1; tick(); imr_we = 1'b0;
  endtask

  task automatic pulse_inta(input logic [7:0] expected_vec);
    exp_q.push_back(expected_vec);
    inta = 1'b1; tick(); inta = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1; tick(); eoi = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; irq = 8'h00; nmi_in = 1'b0; imr_we = 1'b0; imr_wdata = 8'h00;
    eoi = 1'b0; inta = 1'b0; nmia = 1'b0;
    tick(2);
    rst = 1'b0;
    tick();
    total_cnt++; if ({intr, nmir, vec_valid} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {intr, nmir, vec_valid}); else pass_cnt++;
    total_cnt++; if (vec !== 8'h00) $display("FAIL reset_vec got=%h exp=00", vec); else pass_cnt++;
    total_cnt++; if ({irr, isr} !== 16'h0000) $display("FAIL reset_irr_isr got=%h exp=0000", {irr, isr}); else pass_cnt++;
    total_cnt++; if (imr !== 8'hFF) $display("FAIL reset_imr got=%h exp=ff", imr); else pass_cnt++;
  endtask

  task automatic test_basic();
    write_imr(8'h00);
    total_cnt++; if (imr !== 8'h00) $display("FAIL basic_imr got=%h exp=00", imr); else pass_cnt++;
    irq = 8'h08; tick();
    total_cnt++; if (irr !== 8'h08 || intr !== 1'b0) $display("FAIL basic_irr got=%h/%b exp=08/0", irr, intr); else pass_cnt++;
    tick();
    total_cnt++; if (intr !== 1'b1) $display("FAIL basic_intr got=%b exp=1", intr); else pass_cnt++;
    pulse_inta(8'h0B);
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    total_cnt++; if (vec_valid !== 1'b1 || vec !== exp_v) $display("FAIL basic_vec got=%b/%h exp=1/%h", vec_valid, vec, exp_v); else pass_cnt++;
    total_cnt++; if (isr !== 8'h08 || irr !== 8'h00) $display("FAIL basic_ack got isr=%h irr=%h exp=08/00", isr, irr); else pass_cnt++;
    tick();
    total_cnt++; if (vec_valid !== 1'b0 || vec !== 8'h0B || intr !== 1'b0) $display("FAIL basic_after got=%b/%h/%b exp=0/0b/0", vec_valid, vec, intr); else pass_cnt++;
    irq = 8'h00; pulse_eoi();
    total_cnt++; if (isr !== 8'h00) $display("FAIL basic_eoi got=%h exp=00", isr); else pass_cnt++;
  endtask

  task automatic test_nested();
    irq = 8'h20; tick();
    irq = 8'h24; tick();
    total_cnt++; if (irr !== 8'h24 || intr !== 1'b1) $display("FAIL nest_pend got=%h/%b exp=24/1", irr, intr); else pass_cnt++;
    pulse_inta(8'h0A);
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    total_cnt++; if (vec_valid !== 1'b1 || vec !== exp_v) $display("FAIL nest_vec1 got=%b/%h exp=1/%h", vec_valid, vec, exp_v); else pass_cnt++;
    total_cnt++; if (isr !== 8'h04 || irr !== 8'h20) $display("FAIL nest_ack1 got isr=%h irr=%h exp=04/20", isr, irr); else pass_cnt++;
    tick(3);
    total_cnt++; if (intr !== 1'b0) $display("FAIL nest_blocked got=%b exp=0", intr); else pass_cnt++;
    pulse_eoi();
    total_cnt++; if (isr !== 8'h00) $display("FAIL nest_eoi got=%h exp=00", isr); else pass_cnt++;
    tick();
    total_cnt++; if (intr !== 1'b1) $display("FAIL nest_unblock got=%b exp=1", intr); else pass_cnt++;
    pulse_inta(8'h0D);
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    total_cnt++; if (vec_valid !== 1'b1 || vec !== exp_v || isr !== 8'h20) $display("FAIL nest_vec2 got=%b/%h isr=%h exp=1/%h/20", vec_valid, vec, isr, exp_v); else pass_cnt++;
    irq = 8'h00; pulse_eoi();
  endtask

  task automatic test_preempt();
    irq = 8'h04; tick(2);
    pulse_inta(8'h0A);
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    total_cnt++; if (vec !== exp_v || isr !== 8'h04) $display("FAIL pre_first got=%h isr=%h exp=%h/04", vec, isr, exp_v); else pass_cnt++;
    irq = 8'h06; tick(2);
    total_cnt++; if (intr !== 1'b1) $display("FAIL pre_intr got=%b exp=1", intr); else pass_cnt++;
    pulse_inta(8'h09);
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    total_cnt++; if (vec !== exp_v || isr !== 8'h06) $display("FAIL pre_nested got=%h isr=%h exp=%h/06", vec, isr, exp_v); else pass_cnt++;
    pulse_eoi();
    total_cnt++; if (isr !== 8'h04) $display("FAIL pre_eoi got=%h exp=04", isr); else pass_cnt++;
    irq = 8'h07; tick(3);
    eoi = 1'b1;
    pulse_inta(8'h08);
    eoi = 1'b0;
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    total_cnt++; if (vec !== exp_v || isr !== 8'h01) $display("FAIL pre_eoi_inta got=%h isr=%h exp=%h/01", vec, isr, exp_v); else pass_cnt++;
    irq = 8'h00; pulse_eoi();
  endtask

  task automatic test_mask_spurious();
    irq = 8'h10; tick(2);
    total_cnt++; if (intr !== 1'b1) $display("FAIL mask_req got=%b exp=1", intr); else pass_cnt++;
    write_imr(8'h10);
    tick();
    total_cnt++; if (intr !== 1'b0) $display("FAIL mask_drop got=%b exp=0", intr); else pass_cnt++;
    pulse_inta(8'h0F);
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    total_cnt++; if (vec_valid !== 1'b1 || vec !== exp_v) $display("FAIL spur_vec got=%b/%h exp=1/%h", vec_valid, vec, exp_v); else pass_cnt++;
    total_cnt++; if (isr !== 8'h00 || irr !== 8'h10) $display("FAIL spur_state got isr=%h irr=%h exp=00/10", isr, irr); else pass_cnt++;
    write_imr(8'h00);
    tick();
    pulse_inta(8'h0C);
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    total_cnt++; if (vec !== exp_v || isr !== 8'h10) $display("FAIL unmask_vec got=%h isr=%h exp=%h/10", vec, isr, exp_v); else pass_cnt++;
    irq = 8'h00; pulse_eoi();
  endtask

  task automatic test_nmi();
    write_imr(8'hFF);
    nmi_in = 1'b1; tick(); nmi_in = 1'b0;
    total_cnt++; if (nmir !== 1'b1 || intr !== 1'b0) $display("FAIL nmi_set got=%b/%b exp=1/0", nmir, intr); else pass_cnt++;
    nmia = 1'b1; tick(); nmia = 1'b0;
    total_cnt++; if (nmir !== 1'b0 || vec !== 8'h0C) $display("FAIL nmi_clear got=%b/%h exp=0/0c", nmir, vec); else pass_cnt++;
    nmi_in = 1'b1; nmia = 1'b1; tick(); nmi_in = 1'b0; nmia = 1'b0;
    total_cnt++; if (nmir !== 1'b1) $display("FAIL nmi_collide got=%b exp=1", nmir); else pass_cnt++;
    nmia = 1'b1; tick(); nmia = 1'b0;
  endtask

  task automatic test_reset_mid();
    write_imr(8'h00);
    irq = 8'h01; tick(2);
    pulse_inta(8'h08);
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    total_cnt++; if (vec_valid !== 1'b1 || vec !== exp_v || isr !== 8'h01) $display("FAIL rmid_ack got=%b/%h isr=%h exp=1/%h/01", vec_valid, vec, isr, exp_v); else pass_cnt++;
    rst = 1'b1; tick(); rst = 1'b0;
    total_cnt++; if ({intr, nmir, vec_valid, vec, irr, isr, imr} !== {3'b000, 8'h00, 8'h00, 8'h00, 8'hFF})
      $display("FAIL rmid_reset got=%b/%b/%b/%h/%h/%h/%h exp=0/0/0/00/00/00/ff", intr, nmir, vec_valid, vec, irr, isr, imr);
    else pass_cnt++;
    tick();
    total_cnt++; if (irr !== 8'h01) $display("FAIL rmid_held_edge got=%h exp=01", irr); else pass_cnt++;
    irq = 8'h00;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nested();
    test_preempt();
    test_mask_spurious();
    test_nmi();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
